// File: rtl/shift_queue_multiport_pkg.sv
// Shared issue-queue core configuration: IIQ/LSQ sizing constants, the entry
// payload type and a popcount helper used by the queue storage.
package shift_queue_multiport_pkg;

    // Integer issue queue geometry
    localparam int IIQ_DEPTH = 8;
    localparam int IIQ_WIDTH = 32;
    localparam int IIQ_N_ENQ = 2;
    localparam int IIQ_N_DEQ = 2;

    // Load/store issue queue geometry
    localparam int LSQ_DEPTH = 16;
    localparam int LSQ_WIDTH = 64;
    localparam int LSQ_N_ENQ = 2;
    localparam int LSQ_N_DEQ = 1;

    // Payload carried by one integer issue-queue entry
    typedef struct packed {
        logic [IIQ_WIDTH-1:0] payload;
    } iiq_entry_t;

    // Popcount helper works on a fixed wide vector; callers zero-extend
    localparam int PC_MAX_W = 64;
    localparam int PC_CNT_W = $clog2(PC_MAX_W + 1);

    function automatic logic [PC_CNT_W-1:0] popcount(input logic [PC_MAX_W-1:0] v);
        logic [PC_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < PC_MAX_W; i++) begin
            c = c + PC_CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/shift_queue_multiport_prefix_popcount.sv
// Exclusive prefix popcount: prefix_o[i] = number of set bits in vec_i[i-1:0].
// Provides both the collapse shift distance of each entry and the rank of each
// selected entry among the dequeue lanes.
module shift_queue_multiport_prefix_popcount #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         vec_i,
    output logic [N-1:0][CW-1:0] prefix_o,
    output logic [CW-1:0]        total_o
);

    logic [CW-1:0] acc;

    // Running sum: each bit sees the count of set bits strictly below it
    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            prefix_o[i] = acc;
            acc         = acc + CW'(vec_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/shift_queue_multiport.sv
// Collapsing, age-ordered multi-port issue-queue storage. Entry 0 is the
// oldest; dequeues may remove any entries, survivors slide down to close the
// gaps, and new entries are appended behind the youngest survivor.
module shift_queue_multiport
    import shift_queue_multiport_pkg::*;
#(
    parameter int N_ENTRIES   = IIQ_DEPTH,
    parameter int ENTRY_WIDTH = IIQ_WIDTH,
    parameter int N_ENQ       = IIQ_N_ENQ,
    parameter int N_DEQ       = IIQ_N_DEQ,
    parameter int CNT_WIDTH   = $clog2(N_ENTRIES + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_aL,
    input  logic                                  flush,
    output logic                                  enq_ready,
    input  logic [N_ENQ-1:0]                      enq_valid,
    input  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]     enq_data,
    input  logic                                  deq_ready,
    input  logic [N_ENTRIES-1:0]                  deq_sel_mask,
    output logic [N_DEQ-1:0]                      deq_valid,
    output logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]     deq_data,
    input  logic [N_ENTRIES-1:0]                  wr_en,
    input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] wr_data,
    output logic [N_ENTRIES-1:0]                  entry_valid,
    output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_douts,
    output logic [CNT_WIDTH-1:0]                  count
);

    logic [CNT_WIDTH-1:0]                  count_q, count_d;
    logic [ENTRY_WIDTH-1:0]                entry_q [N_ENTRIES];
    logic [ENTRY_WIDTH-1:0]                entry_d [N_ENTRIES];

    logic [N_ENTRIES-1:0]                  valid_vec;
    logic [N_ENTRIES-1:0]                  sel_eff;
    logic [N_ENTRIES-1:0]                  deq_fire;
    logic [N_ENTRIES-1:0]                  survive;
    logic [N_ENTRIES-1:0][CNT_WIDTH-1:0]   sel_prefix;
    logic [CNT_WIDTH-1:0]                  sel_total;
    logic [N_ENTRIES-1:0][CNT_WIDTH-1:0]   new_idx;
    logic [ENTRY_WIDTH-1:0]                moved [N_ENTRIES];

    logic [PC_MAX_W-1:0]                   enq_vec_ext;
    logic [CNT_WIDTH-1:0]                  n_enq, n_deq, enq_base;
    logic [N_ENQ-1:0]                      enq_plus1;

    // Occupancy is always a prefix: entry i is live iff i < count
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            valid_vec[i] = (CNT_WIDTH'(i) < count_q);
        end
    end

    assign entry_valid = valid_vec;
    assign count       = count_q;

    // Selections on empty slots are ignored so lanes never expose stale data
    assign sel_eff   = deq_sel_mask & valid_vec;
    assign deq_fire  = deq_ready ? sel_eff : '0;

    // Rank of every selected entry; the same ranks give collapse distances
    shift_queue_multiport_prefix_popcount #(
        .N  (N_ENTRIES),
        .CW (CNT_WIDTH)
    ) u_sel_prefix (
        .vec_i    (sel_eff),
        .prefix_o (sel_prefix),
        .total_o  (sel_total)
    );

    // Enqueue admission looks only at registered occupancy, never at deq_*
    assign enq_ready = (count_q <= CNT_WIDTH'(N_ENTRIES - N_ENQ));

    // Lane counts for this cycle's occupancy update
    always_comb begin
        enq_vec_ext                = '0;
        enq_vec_ext[N_ENQ-1:0]     = enq_valid;
        n_enq    = enq_ready ? CNT_WIDTH'(popcount(enq_vec_ext)) : '0;
        n_deq    = deq_ready ? sel_total : '0;
        enq_base = count_q - n_deq;
        count_d  = flush ? '0 : (count_q + n_enq - n_deq);
    end

    // Dequeue lanes: lane k is an AND-OR mux over entries whose rank is k
    always_comb begin
        for (int k = 0; k < N_DEQ; k++) begin
            deq_valid[k] = (int'(sel_total) > k);
            deq_data[k]  = '0;
            for (int j = 0; j < N_ENTRIES; j++) begin
                deq_data[k] = deq_data[k] |
                    ({ENTRY_WIDTH{sel_eff[j] && (int'(sel_prefix[j]) == k)}} & entry_q[j]);
            end
        end
    end

    // Per old entry: does it survive, where does it land, and with what value
    always_comb begin
        for (int j = 0; j < N_ENTRIES; j++) begin
            survive[j] = valid_vec[j] & ~deq_fire[j];
            new_idx[j] = CNT_WIDTH'(j) - (deq_ready ? sel_prefix[j] : '0);
            moved[j]   = wr_en[j] ? wr_data[j] : entry_q[j];
        end
    end

    // Per destination slot: one-hot choice of hold, shifted old entry, or enq lane
    for (genvar i = 0; i < N_ENTRIES; i++) begin : g_entry
        logic [N_ENTRIES-1:0]   src_old;
        logic [N_ENQ-1:0]       src_enq;
        logic                   take;
        logic [ENTRY_WIDTH-1:0] mux_val;

        // Build the source selects and the AND-OR merge for slot i
        always_comb begin
            src_old = '0;
            src_enq = '0;
            mux_val = '0;
            for (int j = 0; j < N_ENTRIES; j++) begin
                src_old[j] = survive[j] && (new_idx[j] == CNT_WIDTH'(i));
                mux_val    = mux_val | ({ENTRY_WIDTH{src_old[j]}} & moved[j]);
            end
            for (int k = 0; k < N_ENQ; k++) begin
                src_enq[k] = enq_ready && enq_valid[k] &&
                             ((enq_base + CNT_WIDTH'(k)) == CNT_WIDTH'(i));
                mux_val    = mux_val | ({ENTRY_WIDTH{src_enq[k]}} & enq_data[k]);
            end
            take = (|src_old) | (|src_enq);
        end

        assign entry_d[i] = take ? mux_val : entry_q[i];
    end

    // Occupancy register; flush is folded into count_d
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload registers; contents beyond the occupied prefix are don't-care
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Registered payloads driven straight out
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            entry_douts[i] = entry_q[i];
        end
    end

    assign enq_plus1 = enq_valid + N_ENQ'(1);

    // Input legality and structural invariants
    a_enq_prefix: assert property (@(posedge clk) disable iff (!rst_aL)
        (enq_valid & enq_plus1) == '0);
    a_deq_subset: assert property (@(posedge clk) disable iff (!rst_aL)
        (deq_sel_mask & ~valid_vec) == '0);
    a_deq_lanes: assert property (@(posedge clk) disable iff (!rst_aL)
        sel_total <= CNT_WIDTH'(N_DEQ));
    a_count_max: assert property (@(posedge clk) disable iff (!rst_aL)
        count_q <= CNT_WIDTH'(N_ENTRIES));

endmodule

// File: tb/tb_shift_queue_multiport.sv
// Self-checking bench for shift_queue_multiport: directed scenarios followed
// by randomized legal traffic, all compared against a queue-based model.
module tb_shift_queue_multiport;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int NE = 2;
    localparam int ND = 2;
    localparam int CW = 4;

    logic                clk = 1'b0;
    logic                rst_aL;
    logic                flush;
    logic                enq_ready;
    logic [NE-1:0]       enq_valid;
    logic [NE-1:0][W-1:0] enq_data;
    logic                deq_ready;
    logic [N-1:0]        deq_sel_mask;
    logic [ND-1:0]       deq_valid;
    logic [ND-1:0][W-1:0] deq_data;
    logic [N-1:0]        wr_en;
    logic [N-1:0][W-1:0] wr_data;
    logic [N-1:0]        entry_valid;
    logic [N-1:0][W-1:0] entry_douts;
    logic [CW-1:0]       count;

    shift_queue_multiport #(
        .N_ENTRIES   (N),
        .ENTRY_WIDTH (W),
        .N_ENQ       (NE),
        .N_DEQ       (ND),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst_aL       (rst_aL),
        .flush        (flush),
        .enq_ready    (enq_ready),
        .enq_valid    (enq_valid),
        .enq_data     (enq_data),
        .deq_ready    (deq_ready),
        .deq_sel_mask (deq_sel_mask),
        .deq_valid    (deq_valid),
        .deq_data     (deq_data),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .entry_valid  (entry_valid),
        .entry_douts  (entry_douts),
        .count        (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: oldest element at index 0
    logic [W-1:0] mq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        enq_valid    = '0;
        enq_data     = '0;
        deq_ready    = 1'b0;
        deq_sel_mask = '0;
        wr_en        = '0;
        wr_data      = '0;
    endtask

    task automatic check_state(input string ph);
        int n;
        n = mq.size();
        check($sformatf("%s_count", ph), 64'(count), 64'(n));
        check($sformatf("%s_valid", ph), 64'(entry_valid), 64'((1 << n) - 1));
        check($sformatf("%s_enq_ready", ph), 64'(enq_ready), 64'((N - n) >= NE));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_dout%0d", ph, i), 64'(entry_douts[i]), 64'(mq[i]));
        end
    endtask

    // Lane k shows the k-th lowest selected entry, independent of deq_ready/flush
    task automatic check_deq(input string ph);
        int idx[$];
        bit ev;
        logic [W-1:0] ed;
        for (int j = 0; j < N; j++) begin
            if (deq_sel_mask[j]) idx.push_back(j);
        end
        for (int k = 0; k < ND; k++) begin
            ev = (k < idx.size());
            ed = ev ? mq[idx[k]] : '0;
            check($sformatf("%s_deq_valid%0d", ph, k), 64'(deq_valid[k]), 64'(ev));
            check($sformatf("%s_deq_data%0d", ph, k), 64'(deq_data[k]), 64'(ed));
        end
    endtask

    task automatic model_step();
        logic [W-1:0] nq[$];
        bit room;
        room = (N - mq.size()) >= NE;
        if (flush) begin
            mq.delete();
            return;
        end
        for (int j = 0; j < mq.size(); j++) begin
            if (!(deq_ready && deq_sel_mask[j])) begin
                nq.push_back(wr_en[j] ? wr_data[j] : mq[j]);
            end
        end
        if (room) begin
            for (int k = 0; k < NE; k++) begin
                if (enq_valid[k]) nq.push_back(enq_data[k]);
            end
        end
        mq = nq;
    endtask

    // Inputs are already driven; check comb outputs, clock once, check state
    task automatic do_cycle(input string ph);
        #1;
        check_deq(ph);
        model_step();
        @(posedge clk);
        #1;
        check_state(ph);
    endtask

    task automatic enq2(input logic [W-1:0] a, input logic [W-1:0] b);
        idle();
        enq_valid   = 2'b11;
        enq_data[0] = a;
        enq_data[1] = b;
        do_cycle("enq2");
    endtask

    task automatic enq1(input logic [W-1:0] a);
        idle();
        enq_valid   = 2'b01;
        enq_data[0] = a;
        do_cycle("enq1");
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        do_cycle("flush");
    endtask

    localparam logic [W-1:0] VA = 32'hA0A0_0001;
    localparam logic [W-1:0] VB = 32'hB0B0_0002;
    localparam logic [W-1:0] VC = 32'hC0C0_0003;
    localparam logic [W-1:0] VD = 32'hD0D0_0004;
    localparam logic [W-1:0] VE = 32'hE0E0_0005;
    localparam logic [W-1:0] VF = 32'hF0F0_0006;

    initial begin
        rst_aL = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_aL = 1'b1;

        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(entry_valid), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_deq_data", 64'(deq_data), 64'd0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_dout%0d", i), 64'(entry_douts[i]), 64'd0);
        end

        // Two double enqueues
        enq2(VA, VB);
        enq2(VC, VD);
        check("abcd_count", 64'(count), 64'd4);
        check("abcd_valid", 64'(entry_valid), 64'h0F);
        check("abcd_enq_ready", 64'(enq_ready), 64'd1);
        check("abcd_d0", 64'(entry_douts[0]), 64'(VA));
        check("abcd_d3", 64'(entry_douts[3]), 64'(VD));

        // Out-of-order double dequeue of entries 0 and 2
        idle();
        deq_ready    = 1'b1;
        deq_sel_mask = 8'b0000_0101;
        #1;
        check("ooo_lane0", 64'(deq_data[0]), 64'(VA));
        check("ooo_lane1", 64'(deq_data[1]), 64'(VC));
        do_cycle("ooo");
        check("ooo_count", 64'(count), 64'd2);
        check("ooo_d0", 64'(entry_douts[0]), 64'(VB));
        check("ooo_d1", 64'(entry_douts[1]), 64'(VD));

        // Dequeue and enqueue together
        idle();
        deq_ready    = 1'b1;
        deq_sel_mask = 8'b01;
        enq_valid    = 2'b11;
        enq_data[0]  = VE;
        enq_data[1]  = VF;
        do_cycle("deqenq");
        check("deqenq_count", 64'(count), 64'd3);
        check("deqenq_d0", 64'(entry_douts[0]), 64'(VD));

        // Same with deq_ready low: nothing leaves
        do_flush();
        enq2(VB, VD);
        idle();
        deq_ready    = 1'b0;
        deq_sel_mask = 8'b01;
        enq_valid    = 2'b11;
        enq_data[0]  = VE;
        enq_data[1]  = VF;
        do_cycle("noready");
        check("noready_count", 64'(count), 64'd4);
        check("noready_d0", 64'(entry_douts[0]), 64'(VB));

        // In-place write travels with the shift
        do_flush();
        enq2(32'd10, 32'd20);
        enq1(32'd30);
        idle();
        deq_ready    = 1'b1;
        deq_sel_mask = 8'b001;
        wr_en[2]     = 1'b1;
        wr_data[2]   = 32'd33;
        do_cycle("wrshift");
        check("wrshift_d1", 64'(entry_douts[1]), 64'd33);

        // Write to the entry being dequeued is dropped
        do_flush();
        enq2(32'd10, 32'd20);
        enq1(32'd30);
        idle();
        deq_ready    = 1'b1;
        deq_sel_mask = 8'b001;
        wr_en[0]     = 1'b1;
        wr_data[0]   = 32'd99;
        do_cycle("wrdrop");
        check("wrdrop_d0", 64'(entry_douts[0]), 64'd20);
        check("wrdrop_d1", 64'(entry_douts[1]), 64'd30);

        // Fill boundaries
        do_flush();
        enq2(32'h11, 32'h12);
        enq2(32'h13, 32'h14);
        enq2(32'h15, 32'h16);
        check("fill6_enq_ready", 64'(enq_ready), 64'd1);
        enq1(32'h17);
        check("fill7_enq_ready", 64'(enq_ready), 64'd0);
        idle();
        deq_ready    = 1'b1;
        deq_sel_mask = 8'b01;
        enq_valid    = 2'b11;
        enq_data[0]  = 32'h18;
        enq_data[1]  = 32'h19;
        #1;
        check("fill7_conservative", 64'(enq_ready), 64'd0);
        do_cycle("fill7deq");
        check("fill7deq_count", 64'(count), 64'd6);
        enq2(32'h1A, 32'h1B);
        check("full_count", 64'(count), 64'd8);
        check("full_valid", 64'(entry_valid), 64'hFF);

        // Flush wins over enq/deq at count 5
        do_flush();
        enq2(32'h21, 32'h22);
        enq2(32'h23, 32'h24);
        enq1(32'h25);
        idle();
        flush        = 1'b1;
        deq_ready    = 1'b1;
        deq_sel_mask = 8'b011;
        enq_valid    = 2'b11;
        enq_data[0]  = 32'h26;
        enq_data[1]  = 32'h27;
        do_cycle("flushwin");
        check("flushwin_count", 64'(count), 64'd0);

        // Asynchronous reset between clock edges
        enq2(32'h31, 32'h32);
        enq2(32'h33, 32'h34);
        idle();
        #3;
        rst_aL = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(entry_valid), 64'd0);
        check("arst_enq_ready", 64'(enq_ready), 64'd1);
        check("arst_deq_valid", 64'(deq_valid), 64'd0);
        check("arst_dout0", 64'(entry_douts[0]), 64'd0);
        check("arst_dout3", 64'(entry_douts[3]), 64'd0);
        mq.delete();
        #2;
        rst_aL = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_arst");

        // Randomized legal traffic
        for (int c = 0; c < 500; c++) begin
            int n;
            int want;
            idle();
            n = mq.size();
            case ($urandom_range(0, 2))
                0: enq_valid = 2'b00;
                1: enq_valid = 2'b01;
                default: enq_valid = 2'b11;
            endcase
            enq_data[0] = $urandom;
            enq_data[1] = $urandom;
            deq_ready   = ($urandom_range(0, 3) != 0);
            want = $urandom_range(0, (n < ND) ? n : ND);
            while ($countones(deq_sel_mask) < want) begin
                deq_sel_mask[$urandom_range(0, n - 1)] = 1'b1;
            end
            wr_en = 8'($urandom & $urandom);
            for (int i = 0; i < N; i++) wr_data[i] = $urandom;
            flush = ($urandom_range(0, 24) == 0);
            do_cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
